// File: rtl/vend_fsm_multi.sv
// vend_fsm_multi: multi-item vending controller.
// Accumulates coin credit (rejecting coins that would overflow), checks a
// selection against a per-item price table and stock count, issues a
// one-cycle dispense command, then returns change or a refund. An idle
// credit session is refunded after TIMEOUT quiet cycles.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   coin_valid, coin_value   coin inserted this cycle and its value
//   sel_valid, sel_item      selection pressed this cycle and its index
//   cancel                   customer cancel / refund request
//   done                     mechanism reports dispense complete
//   restock                  reload every stock counter (IDLE only)
//   state                    FSM state (IDLE=0, CREDIT=1, DISPENSE=2, RETURN=3)
//   credit                   current credit
//   dispense, dispense_item  dispense command pulse and item (held in DISPENSE)
//   change_valid, change_amount  change/refund strobe and amount
//   coin_reject, insufficient, sold_out  one-cycle status pulses
module vend_fsm_multi #(
    parameter int unsigned NUM_ITEMS  = 4,
    parameter int unsigned SEL_W      = 2,
    parameter int unsigned CREDIT_W   = 8,
    parameter int unsigned STOCK_W    = 4,
    parameter int unsigned INIT_STOCK = 5,
    parameter int unsigned TIMEOUT    = 32,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = 32'h191E2D3C
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [CREDIT_W-1:0] coin_value,
    input  logic                sel_valid,
    input  logic [SEL_W-1:0]    sel_item,
    input  logic                cancel,
    input  logic                done,
    input  logic                restock,
    output logic [2:0]          state,
    output logic [CREDIT_W-1:0] credit,
    output logic                dispense,
    output logic [SEL_W-1:0]    dispense_item,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amount,
    output logic                coin_reject,
    output logic                insufficient,
    output logic                sold_out
);

    localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'b000,
        S_CREDIT   = 3'b001,
        S_DISPENSE = 3'b010,
        S_RETURN   = 3'b011
    } state_t;

    state_t              st, st_nxt;
    logic [TO_W-1:0]     tcnt, tcnt_nxt;
    logic [STOCK_W-1:0]  stock     [NUM_ITEMS];
    logic [STOCK_W-1:0]  stock_nxt [NUM_ITEMS];
    logic [CREDIT_W-1:0] price_tab [NUM_ITEMS];
    logic [CREDIT_W-1:0] price_sel;
    logic [CREDIT_W:0]   sum;
    logic                sel_ok;

    logic [CREDIT_W-1:0] credit_nxt, camt_nxt;
    logic [SEL_W-1:0]    ditem_nxt;
    logic                disp_nxt, cv_nxt, rej_nxt, ins_nxt, sold_nxt;

    // Unpack the flat price parameter into a lookup table.
    for (genvar g = 0; g < int'(NUM_ITEMS); g++) begin : g_price
        assign price_tab[g] = PRICES[g*CREDIT_W +: CREDIT_W];
    end

    assign price_sel = price_tab[sel_item];
    assign sel_ok    = (32'(sel_item) < NUM_ITEMS);
    // One extra bit so an overflowing coin can be detected and rejected.
    assign sum       = {1'b0, credit} + {1'b0, coin_value};
    assign state     = st;

    // Next-state and next-output logic.
    always_comb begin
        st_nxt     = st;
        tcnt_nxt   = tcnt;
        stock_nxt  = stock;
        credit_nxt = credit;
        camt_nxt   = change_amount;
        ditem_nxt  = dispense_item;
        disp_nxt   = 1'b0;
        cv_nxt     = 1'b0;
        rej_nxt    = 1'b0;
        ins_nxt    = 1'b0;
        sold_nxt   = 1'b0;

        case (st)
            S_IDLE: begin
                if (restock) begin
                    for (int i = 0; i < int'(NUM_ITEMS); i++) begin
                        stock_nxt[i] = STOCK_W'(INIT_STOCK);
                    end
                end
                if (coin_valid && (coin_value != '0)) begin
                    credit_nxt = coin_value;
                    tcnt_nxt   = '0;
                    st_nxt     = S_CREDIT;
                end
            end

            S_CREDIT: begin
                if (cancel) begin
                    rej_nxt  = coin_valid;
                    cv_nxt   = 1'b1;
                    camt_nxt = credit;
                    st_nxt   = S_RETURN;
                end else if (sel_valid) begin
                    tcnt_nxt = '0;
                    rej_nxt  = coin_valid;
                    if (!sel_ok || (stock[sel_item] == '0)) begin
                        sold_nxt = 1'b1;
                    end else if (credit < price_sel) begin
                        ins_nxt = 1'b1;
                    end else begin
                        disp_nxt              = 1'b1;
                        ditem_nxt             = sel_item;
                        credit_nxt            = credit - price_sel;
                        stock_nxt[sel_item]   = stock[sel_item] - STOCK_W'(1);
                        st_nxt                = S_DISPENSE;
                    end
                end else if (coin_valid) begin
                    tcnt_nxt = '0;
                    if (sum[CREDIT_W]) begin
                        rej_nxt = 1'b1;
                    end else begin
                        credit_nxt = sum[CREDIT_W-1:0];
                    end
                end else if (tcnt == TO_W'(TIMEOUT - 1)) begin
                    // This quiet edge is the TIMEOUT-th one: refund.
                    cv_nxt   = 1'b1;
                    camt_nxt = credit;
                    st_nxt   = S_RETURN;
                end else begin
                    tcnt_nxt = tcnt + TO_W'(1);
                end
            end

            S_DISPENSE: begin
                rej_nxt = coin_valid;
                if (done) begin
                    if (credit != '0) begin
                        cv_nxt   = 1'b1;
                        camt_nxt = credit;
                        st_nxt   = S_RETURN;
                    end else begin
                        st_nxt = S_IDLE;
                    end
                end
            end

            S_RETURN: begin
                credit_nxt = '0;
                st_nxt     = S_IDLE;
            end

            default: begin
                credit_nxt = '0;
                st_nxt     = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            st            <= S_IDLE;
            tcnt          <= '0;
            credit        <= '0;
            change_amount <= '0;
            dispense_item <= '0;
            dispense      <= 1'b0;
            change_valid  <= 1'b0;
            coin_reject   <= 1'b0;
            insufficient  <= 1'b0;
            sold_out      <= 1'b0;
            for (int i = 0; i < int'(NUM_ITEMS); i++) begin
                stock[i] <= STOCK_W'(INIT_STOCK);
            end
        end else begin
            st            <= st_nxt;
            tcnt          <= tcnt_nxt;
            credit        <= credit_nxt;
            change_amount <= camt_nxt;
            dispense_item <= ditem_nxt;
            dispense      <= disp_nxt;
            change_valid  <= cv_nxt;
            coin_reject   <= rej_nxt;
            insufficient  <= ins_nxt;
            sold_out      <= sold_nxt;
            for (int i = 0; i < int'(NUM_ITEMS); i++) begin
                stock[i] <= stock_nxt[i];
            end
        end
    end

endmodule
